// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and constants for the four-digit display scanner.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } scan_state_e;

  localparam logic [NUM_DIGITS-1:0] SEL_D0 = 4'b1000;
  localparam logic [NUM_DIGITS-1:0] SEL_D1 = 4'b0100;
  localparam logic [NUM_DIGITS-1:0] SEL_D2 = 4'b0010;
  localparam logic [NUM_DIGITS-1:0] SEL_D3 = 4'b0001;

  // Expressed in the active-high select domain; polarity is applied by an_drive.
  localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = 4'b0000;

  function automatic logic [NUM_DIGITS-1:0] an_drive(input logic [NUM_DIGITS-1:0] sel,
                                                      input bit active_low);
    return active_low ? ~sel : sel;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_digit_sel_decode.sv
// Digit index to active-high one-hot anode select.
module digit_sel_decode
  import display_pkg::*;
(
  input  logic [1:0]            idx,
  output logic [NUM_DIGITS-1:0] sel
);

  always_comb begin
    sel = SEL_D0;
    case (idx)
      2'd0: sel = SEL_D0;
      2'd1: sel = SEL_D1;
      2'd2: sel = SEL_D2;
      2'd3: sel = SEL_D3;
      default: sel = SEL_D0;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed four-digit scanner with dwell/blank timing, frame-aligned
// word updates through a one-entry buffer, and leading-zero blanking.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES  = 100000,
  parameter int unsigned BLANK_CYCLES  = 1000,
  parameter bit          ACTIVE_LOW_AN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic        lz_blank_en,
  output logic [3:0]  an,
  output logic [3:0]  nibble,
  output logic [1:0]  digit_idx,
  output logic        blank,
  output logic        frame_done
);

  localparam int unsigned MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;
  localparam logic [3:0]       AN_OFF     = an_drive(AN_ALL_OFF, ACTIVE_LOW_AN);

  scan_state_e      r_state;
  logic [1:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_active;
  logic [15:0]      r_pending;
  logic             r_pend_full;
  logic [3:0]       r_an;
  logic [3:0]       r_nibble;
  logic             r_blank;
  logic             r_frame_done;
  logic             r_ready;

  scan_state_e      w_state_nxt;
  logic [1:0]       w_idx_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_load;
  logic             w_wrap;
  logic [15:0]      w_active_nxt;
  logic [15:0]      w_pending_nxt;
  logic             w_pend_full_nxt;
  logic [3:0]       w_slice;
  logic             w_lead_zero;
  logic             w_lit;
  logic [3:0]       w_sel;
  logic [3:0]       w_an_nxt;
  logic [3:0]       w_nibble_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_wrap      = 1'b0;
    if (!enable) begin
      w_state_nxt = IDLE;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = SHOW;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
          w_load      = 1'b1;
        end
        SHOW: begin
          if (r_cnt == DWELL_LAST) begin
            w_cnt_nxt = '0;
            if (BLANK_CYCLES == 0) begin
              w_idx_nxt = r_idx + 2'd1;
              w_wrap    = (r_idx == 2'd3);
            end else begin
              w_state_nxt = GAP;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        GAP: begin
          if (r_cnt == BLANK_LAST) begin
            w_state_nxt = SHOW;
            w_cnt_nxt   = '0;
            w_idx_nxt   = r_idx + 2'd1;
            w_wrap      = (r_idx == 2'd3);
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Frame load: a pending word wins; otherwise an offered word bypasses the buffer.
  always_comb begin
    w_active_nxt    = r_active;
    w_pending_nxt   = r_pending;
    w_pend_full_nxt = r_pend_full;
    if (w_load || w_wrap) begin
      if (r_pend_full) begin
        w_active_nxt    = r_pending;
        w_pend_full_nxt = 1'b0;
      end else if (data_valid) begin
        w_active_nxt = data_in;
      end
    end else if (data_valid && !r_pend_full) begin
      w_pending_nxt   = data_in;
      w_pend_full_nxt = 1'b1;
    end
  end

  always_comb begin
    w_slice     = w_active_nxt[15:12];
    w_lead_zero = 1'b0;
    case (w_idx_nxt)
      2'd0: begin
        w_slice     = w_active_nxt[15:12];
        w_lead_zero = (w_active_nxt[15:12] == 4'h0);
      end
      2'd1: begin
        w_slice     = w_active_nxt[11:8];
        w_lead_zero = (w_active_nxt[15:8] == 8'h00);
      end
      2'd2: begin
        w_slice     = w_active_nxt[7:4];
        w_lead_zero = (w_active_nxt[15:4] == 12'h000);
      end
      default: begin
        w_slice     = w_active_nxt[3:0];
        w_lead_zero = 1'b0;
      end
    endcase
  end

  digit_sel_decode u_sel (
    .idx (w_idx_nxt),
    .sel (w_sel)
  );

  // Outputs are computed from next-state values so the registered copies line up with the state.
  always_comb begin
    w_lit        = (w_state_nxt == SHOW) && !(lz_blank_en && w_lead_zero);
    w_an_nxt     = an_drive(w_lit ? w_sel : AN_ALL_OFF, ACTIVE_LOW_AN);
    w_nibble_nxt = (w_state_nxt == SHOW) ? w_slice : r_nibble;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_active     <= '0;
      r_pending    <= '0;
      r_pend_full  <= 1'b0;
      r_an         <= AN_OFF;
      r_nibble     <= '0;
      r_blank      <= 1'b1;
      r_frame_done <= 1'b0;
      r_ready      <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_active     <= w_active_nxt;
      r_pending    <= w_pending_nxt;
      r_pend_full  <= w_pend_full_nxt;
      r_an         <= w_an_nxt;
      r_nibble     <= w_nibble_nxt;
      r_blank      <= !w_lit;
      r_frame_done <= w_wrap;
      r_ready      <= !w_pend_full_nxt;
    end
  end

  assign an         = r_an;
  assign nibble     = r_nibble;
  assign digit_idx  = r_idx;
  assign blank      = r_blank;
  assign frame_done = r_frame_done;
  assign data_ready = r_ready;

endmodule
